// File: rtl/mem_stage_pipe.sv
// MIPS MEM stage: MEM/WB pipeline register plus an internal word-organised
// data memory. It supports byte, halfword and word accesses with sign or zero
// extension, detects misaligned accesses, and models a configurable access
// latency. Stalls are signalled back to EX/MEM while an access is in progress.
module mem_stage_pipe #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        wreg_in,
  input  logic        m2reg_in,
  input  logic        wmem_in,
  input  logic [1:0]  size_in,
  input  logic        sext_in,
  input  logic [4:0]  RdRt_in,
  input  logic [31:0] aluresult_in,
  input  logic [31:0] qb_in,
  output logic        stall_out,
  output logic        out_valid,
  output logic        wreg_out,
  output logic        m2reg_out,
  output logic [4:0]  RdRt_out,
  output logic [31:0] aluresult_out,
  output logic [31:0] dataout,
  output logic        misalign_out
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [31:0]        mem [2**ADDR_W];

  logic [ADDR_W-1:0]  widx;
  logic [1:0]         boff;
  logic               mem_op, aligned, misalign, slow_op, accept;
  logic [31:0]        rword, wword, load_val;
  logic [7:0]         lane8;
  logic [15:0]        lane16;

  // Upper address bits are ignored, so accesses wrap around the memory.
  assign widx     = aluresult_in[ADDR_W+1:2];
  assign boff     = aluresult_in[1:0];
  assign mem_op   = in_valid & (m2reg_in | wmem_in);
  assign misalign = mem_op & ~aligned;
  // Only aligned memory accesses pay the latency; with LATENCY=1 nothing stalls.
  assign slow_op  = mem_op & aligned & (LATENCY > 1);
  assign accept   = in_valid & ~stall_out;
  assign rword    = mem[widx];

  // Alignment rule: bytes always; halves on even addresses; words on multiples of 4.
  always_comb begin
    unique case (size_in)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~boff[0];
      default: aligned = (boff == 2'b00);
    endcase
  end

  // Latency FSM: next state, counter and the stall handshake.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (slow_op) begin
          stall_out = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        stall_out = (cnt != CNT_W'(1));
        cnt_nxt   = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Load path: pick the addressed lane and extend it to 32 bits.
  always_comb begin
    lane8    = rword[{boff, 3'b000} +: 8];
    lane16   = rword[{boff[1], 4'b0000} +: 16];
    load_val = rword;
    unique case (size_in)
      2'b00:   load_val = {{24{sext_in & lane8[7]}}, lane8};
      2'b01:   load_val = {{16{sext_in & lane16[15]}}, lane16};
      default: load_val = rword;
    endcase
  end

  // Store path: merge the new lanes into the current word, preserving the rest.
  always_comb begin
    wword = rword;
    unique case (size_in)
      2'b00:   wword[{boff, 3'b000} +: 8]     = qb_in[7:0];
      2'b01:   wword[{boff[1], 4'b0000} +: 16] = qb_in[15:0];
      default: wword = qb_in;
    endcase
  end

  // Single memory write, on the accept edge of an aligned store only.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; clearing it would forbid RAM inference. A reset cycle only blocks the write.
    if (!rst && accept && wmem_in && aligned) mem[widx] <= wword;
  end

  // MEM/WB register: bubble while stalled or idle, capture on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      wreg_out      <= 1'b0;
      m2reg_out     <= 1'b0;
      RdRt_out      <= '0;
      aluresult_out <= '0;
      dataout       <= '0;
      misalign_out  <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        wreg_out      <= wreg_in & ~misalign;
        m2reg_out     <= m2reg_in;
        RdRt_out      <= RdRt_in;
        aluresult_out <= aluresult_in;
        dataout       <= (m2reg_in & aligned) ? load_val : 32'h0;
        misalign_out  <= misalign;
      end
    end
  end

endmodule
